// File: rtl/fetch_unit.sv
// PC / instruction-fetch stage: one imem read per instruction, then holds the
// fetched word for decode until it retires; misaligned redirects and memory timeouts lock up in ERR.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misalign_err,
  output logic        fetch_err
);

  localparam int unsigned CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_ERR
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  // imem_addr tracks the PC register directly, so it is registered too.
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_BOOT;
      pc           <= RESET_PC;
      instr        <= NOP;
      instr_valid  <= 1'b0;
      imem_req     <= 1'b0;
      misalign_err <= 1'b0;
      fetch_err    <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      case (state)
        S_BOOT: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end

        S_REQ: begin
          state    <= S_WAIT;
          imem_req <= 1'b0;
          wait_cnt <= '0;
        end

        // rvalid on the last allowed WAIT cycle still wins over the timeout.
        S_WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= S_VALID;
          end else if (wait_cnt == CNT_LAST) begin
            fetch_err <= 1'b1;
            state     <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        S_VALID: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (br_taken && (br_target[1:0] != 2'b00)) begin
              misalign_err <= 1'b1;
              state        <= S_ERR;
            end else begin
              pc       <= br_taken ? br_target : pc + 32'd4;
              imem_req <= 1'b1;
              state    <= S_REQ;
            end
          end
        end

        S_ERR: begin
          instr_valid <= 1'b0;
          imem_req    <= 1'b0;
        end

        default: begin
          state       <= S_BOOT;
          instr_valid <= 1'b0;
          imem_req    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit: per-cycle table plus hand sequences
// for timeout, PC wrap and reset in the middle of a fetch.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_taken;
  logic [31:0] br_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign_err;
  logic        fetch_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .br_taken(br_taken), .br_target(br_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .misalign_err(misalign_err), .fetch_err(fetch_err)
  );

  typedef struct {
    logic        rst, br, stall, rv;
    logic [31:0] tgt, rdata;
    logic        req;
    logic [31:0] pc, instr;
    logic        iv, mis, ferr;
  } vec_t;

  function automatic vec_t mk(logic r, logic b, logic [31:0] t, logic s, logic v, logic [31:0] d,
                              logic q, logic [31:0] p, logic [31:0] i, logic iv, logic m, logic f);
    vec_t x;
    x.rst = r; x.br = b; x.tgt = t; x.stall = s; x.rv = v; x.rdata = d;
    x.req = q; x.pc = p; x.instr = i; x.iv = iv; x.mis = m; x.ferr = f;
    return x;
  endfunction

  // Drive one cycle of inputs, clock once, then check registered outputs.
  task automatic apply(input vec_t v, input string name);
    rst = v.rst; br_taken = v.br; br_target = v.tgt; stall = v.stall;
    imem_rvalid = v.rv; imem_rdata = v.rdata;
    @(posedge clk);
    #1;
    n_vec++;
    if (imem_req !== v.req || imem_addr !== v.pc || pc !== v.pc || instr !== v.instr ||
        instr_valid !== v.iv || misalign_err !== v.mis || fetch_err !== v.ferr) begin
      n_err++;
      $display("FAIL %s: got req=%b addr=%h pc=%h instr=%h iv=%b mis=%b ferr=%b, want req=%b pc=%h instr=%h iv=%b mis=%b ferr=%b",
               name, imem_req, imem_addr, pc, instr, instr_valid, misalign_err, fetch_err,
               v.req, v.pc, v.instr, v.iv, v.mis, v.ferr);
    end
  endtask

  task automatic s(input string name, input logic r, input logic b, input logic [31:0] t,
                   input logic st, input logic v, input logic [31:0] d, input logic q,
                   input logic [31:0] p, input logic [31:0] i, input logic iv,
                   input logic m, input logic f);
    apply(mk(r, b, t, st, v, d, q, p, i, iv, m, f), name);
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; br_taken = 1'b0; br_target = '0; stall = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;

    // rst br tgt stall rv rdata | req pc instr iv mis ferr
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h00, NOP, 0, 0, 0));               // reset
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h00, NOP, 0, 0, 0));               // REQ addr 0
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h00, NOP, 0, 0, 0));               // WAIT
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h00500093, 0, 32'h00, 32'h00500093, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h04, 32'h00500093, 0, 0, 0));      // pc+4
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h04, 32'h00500093, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h00a00113, 0, 32'h04, 32'h00a00113, 1, 0, 0));
    tbl.push_back(mk(0, 1, 32'h10, 0, 0, 0, 1, 32'h10, 32'h00a00113, 0, 0, 0)); // branch to 0x10
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h10, 32'h00a00113, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h00000463, 0, 32'h10, 32'h00000463, 1, 0, 0));
    tbl.push_back(mk(0, 1, 32'h40, 0, 0, 0, 1, 32'h40, 32'h00000463, 0, 0, 0)); // 0x10 -> 0x40
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h40, 32'h00000463, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h12345678, 0, 32'h40, 32'h12345678, 1, 0, 0));
    for (int k = 0; k < 5; k++)                                                  // stall beats branch
      tbl.push_back(mk(0, 1, 32'h80, 1, (k == 4), 32'hdeadbeef, 0, 32'h40, 32'h12345678, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h44, 32'h12345678, 0, 0, 0));      // release -> pc+4
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h44, 32'h12345678, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0badf00d, 0, 32'h44, 32'h0badf00d, 1, 0, 0));
    tbl.push_back(mk(0, 1, 32'h42, 0, 0, 0, 0, 32'h44, 32'h0badf00d, 0, 1, 0)); // misaligned
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h11111111, 0, 32'h44, 32'h0badf00d, 0, 1, 0));
    tbl.push_back(mk(0, 1, 32'h100, 0, 0, 0, 0, 32'h44, 32'h0badf00d, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h00, NOP, 0, 0, 0));               // reset clears errors

    foreach (tbl[k]) apply(tbl[k], $sformatf("tbl%0d", k));

    // Timeout: 16 WAIT cycles with no rvalid
    s("to_req", 0, 0, 0, 0, 0, 0, 1, 32'h0, NOP, 0, 0, 0);
    s("to_wait", 0, 0, 0, 0, 0, 0, 0, 32'h0, NOP, 0, 0, 0);
    for (int k = 1; k < 16; k++)
      s($sformatf("to_w%0d", k), 0, 0, 0, 0, 0, 0, 0, 32'h0, NOP, 0, 0, 0);
    s("to_err", 0, 0, 0, 0, 0, 0, 0, 32'h0, NOP, 0, 0, 1);
    s("to_hold", 0, 0, 0, 0, 1, 32'h22222222, 0, 32'h0, NOP, 0, 0, 1);

    // rvalid on the 16th WAIT cycle still succeeds
    s("ok_rst", 1, 0, 0, 0, 0, 0, 0, 32'h0, NOP, 0, 0, 0);
    s("ok_req", 0, 0, 0, 0, 0, 0, 1, 32'h0, NOP, 0, 0, 0);
    s("ok_wait", 0, 0, 0, 0, 0, 0, 0, 32'h0, NOP, 0, 0, 0);
    for (int k = 1; k < 16; k++)
      s($sformatf("ok_w%0d", k), 0, 0, 0, 0, 0, 0, 0, 32'h0, NOP, 0, 0, 0);
    s("ok_last", 0, 0, 0, 0, 1, 32'h33333333, 0, 32'h0, 32'h33333333, 1, 0, 0);

    // PC wrap: 0xFFFFFFFC + 4 -> 0
    s("wr_br", 0, 1, 32'hFFFFFFFC, 0, 0, 0, 1, 32'hFFFFFFFC, 32'h33333333, 0, 0, 0);
    s("wr_wait", 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 32'h33333333, 0, 0, 0);
    s("wr_valid", 0, 0, 0, 0, 1, 32'h44444444, 0, 32'hFFFFFFFC, 32'h44444444, 1, 0, 0);
    s("wr_zero", 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h44444444, 0, 0, 0);
    s("wr_wait0", 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h44444444, 0, 0, 0);
    s("wr_valid0", 0, 0, 0, 0, 1, 32'h55555555, 0, 32'h0, 32'h55555555, 1, 0, 0);
    s("mr_req4", 0, 0, 0, 0, 0, 0, 1, 32'h4, 32'h55555555, 0, 0, 0);
    s("mr_wait4", 0, 0, 0, 0, 0, 0, 0, 32'h4, 32'h55555555, 0, 0, 0);

    // Reset mid-WAIT with rvalid present, then a late rvalid is dropped
    s("mr_rst", 1, 0, 0, 0, 1, 32'h66666666, 0, 32'h0, NOP, 0, 0, 0);
    s("mr_req", 0, 0, 0, 0, 1, 32'h77777777, 1, 32'h0, NOP, 0, 0, 0);
    s("mr_wait", 0, 0, 0, 0, 0, 0, 0, 32'h0, NOP, 0, 0, 0);
    s("mr_still", 0, 0, 0, 0, 0, 0, 0, 32'h0, NOP, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
